// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gen
// Purpose  : Multi-channel rectangular waveform generator. Period and duty are
//            double-buffered and applied at period boundaries. Optional tick
//            output enabled by defining PWM_GEN_TICK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gen #(
    parameter  int CHANNELS = 2,
    parameter  int CLK_MHZ  = 50,
    parameter  int FREQ_KHZ = 100,
    parameter  int DUTY     = 25,
    parameter  int WIDTH    = 16,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic                wr_sel,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] out
`ifdef PWM_GEN_TICK_EN
    ,
    output logic [CHANNELS-1:0] tick
`endif
);

    localparam int P_DEF = 1000 * CLK_MHZ / FREQ_KHZ;
    localparam int D_DEF = P_DEF * DUTY / 100;
    localparam logic [WIDTH-1:0] P_INIT = WIDTH'(P_DEF);
    localparam logic [WIDTH-1:0] D_INIT = WIDTH'(D_DEF);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            state_e           state_q, state_d;
            logic [WIDTH-1:0] cnt_q, cnt_d;
            logic [WIDTH-1:0] pact_q, pact_d, dact_q, dact_d;
            logic [WIDTH-1:0] psh_q, psh_d, dsh_q, dsh_d;
            logic [WIDTH-1:0] pe;
            logic             out_q, out_d;
            logic             wrap, wr_hit;

            // Out-of-range channel indices never match any instance.
            assign wr_hit = wr_en && (wr_ch == CH_W'(i));
            assign pe     = (pact_q == '0) ? WIDTH'(1) : pact_q;
            assign wrap   = (cnt_q == pe - WIDTH'(1));

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                pact_d  = pact_q;
                dact_d  = dact_q;
                psh_d   = (wr_hit && !wr_sel) ? wr_data : psh_q;
                dsh_d   = (wr_hit &&  wr_sel) ? wr_data : dsh_q;
                out_d   = (state_q == S_RUN) && (cnt_q < dact_q);
                case (state_q)
                    S_IDLE: begin
                        cnt_d  = '0;
                        pact_d = psh_q;
                        dact_d = dsh_q;
                        if (en[i]) begin
                            state_d = S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (!en[i]) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else if (wrap) begin
                            // Shadows are sampled pre-write, so a same-edge write waits a period.
                            cnt_d  = '0;
                            pact_d = psh_q;
                            dact_d = dsh_q;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    pact_q  <= P_INIT;
                    dact_q  <= D_INIT;
                    psh_q   <= P_INIT;
                    dsh_q   <= D_INIT;
                    out_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    pact_q  <= pact_d;
                    dact_q  <= dact_d;
                    psh_q   <= psh_d;
                    dsh_q   <= dsh_d;
                    out_q   <= out_d;
                end
            end

            assign out[i] = out_q;

`ifdef PWM_GEN_TICK_EN
            logic tick_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tick_q <= 1'b0;
                end else begin
                    tick_q <= (state_q == S_RUN) && wrap;
                end
            end
            assign tick[i] = tick_q;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
Parametrised multi-channel periodic waveform generator; successor to the fixed single-output clock generator. Each channel produces a rectangular waveform with runtime-programmable period and duty in clk cycles. Compile-time defaults are derived from the clock and target frequency. New period/duty values are double-buffered and applied glitch-free at period boundaries. Used for sampling strobes, test clocks and PWM outputs alongside the UART receiver.

Parameters:
CHANNELS, 2, number of independent output channels (>=1)
CLK_MHZ, 50, input clock frequency in MHz
FREQ_KHZ, 100, default output frequency in kHz
DUTY, 25, default duty cycle in percent (0..100)
WIDTH, 16, period/duty/counter width; must satisfy WIDTH >= $clog2(P_DEF+1)
Derived localparams: P_DEF = 1000*CLK_MHZ/FREQ_KHZ (500 at defaults); D_DEF = P_DEF*DUTY/100 (125); CH_W = max(1, $clog2(CHANNELS))

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en  in  CHANNELS  per-channel run enable
wr_en  in  1  write strobe, one write per cycle
wr_ch  in  CH_W  target channel of the write
wr_sel  in  1  0 = period shadow, 1 = duty shadow
wr_data  in  WIDTH  value written to the selected shadow
out  out  CHANNELS  registered waveform outputs

Behaviour:
- Per channel state: cnt, P_act, D_act (active); P_sh, D_sh (shadow); run flag. All WIDTH bits except run.
- Reset (async, immediate, no clock needed): cnt=0, run=0, out=0, P_act=P_sh=P_DEF, D_act=D_sh=D_DEF. Tick (if compiled) = 0.
- Effective period Pe = (P_act==0) ? 1 : P_act.
- Write: on a clk edge with wr_en=1 and wr_ch < CHANNELS, wr_data is written to the shadow selected by wr_sel. wr_ch >= CHANNELS: ignored, no state change.
- States per channel: IDLE (run=0) and RUN (run=1).
- IDLE: cnt held at 0, out=0, and P_act/D_act are loaded from the shadows every cycle. en=1 -> RUN on the same edge, with cnt=0.
- RUN: en=0 -> IDLE on the next edge, with cnt=0 and out=0 one cycle later. Otherwise:
  - cnt == Pe-1: wrap. cnt<=0, P_act<=P_sh, D_act<=D_sh.
  - Else cnt<=cnt+1.
- Write and wrap on the same edge: the wrap loads the pre-write shadow. The new value applies at the following wrap.
- Output: out <= run & (cnt < D_act). This is a registered compare, so out lags cnt by one cycle. After en rises at edge k, out is first high after edge k+1.
- Each period is Pe cycles: out high D_act cycles, then low Pe-D_act cycles.
- Boundary cases: D_act=0 -> out constant 0. D_act >= Pe -> out constant 1 while running. P_act=0 -> counter stays at 0, out = (D_act != 0).
- Shadow changes never shorten or truncate the period in progress. A P_sh below the current cnt is harmless because it is only applied at the wrap.
- Channels are fully independent; there is no phase relation unless they are enabled on the same edge.

Optional Feature:
Macro PWM_GEN_TICK_EN.
- Defined: adds output port tick (out, CHANNELS bits). tick[i] <= run & wrap_condition, giving a one-cycle pulse in the cycle where cnt has just returned to 0. It is 0 in IDLE and after reset.
- Not defined: no tick port and no tick logic. All other behaviour is identical.

Test Plan:
1. Reset, then en=2'b01 at defaults -> out[0] high 125 cycles, low 375, repeating every 500; out[1] stays 0.
2. ch1 running at defaults; write P=10, D=3 mid-period -> current 500-cycle period completes unchanged, then out[1] goes 3 high / 7 low repeating.
3. ch0 with P=10: write D=0 -> constant 0 after next wrap. Write D=10 -> constant 1. Write P=0, D=1 -> constant 1, cnt stays 0.
4. Write D=5 on the exact edge where cnt==Pe-1 -> the next period still uses the old duty; D=5 appears one period later.
5. Drop en mid-high-phase, re-enable 20 cycles later after writing P=8, D=2 -> out=0 during IDLE. First high occurs 1 cycle after en rises; pattern is 2 high / 6 low. With PWM_GEN_TICK_EN, tick pulses every 8 cycles.
6. Assert rst between clock edges while out=1 -> out drops immediately, and shadows read back as defaults (500/125 waveform on re-enable). With CHANNELS=3, a write with wr_ch=3 changes no channel.
